// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode, FSM state and forward-select encodings shared by pipe_ctrl.
// Defining PIPE_CTRL_FWD_EN turns on operand forwarding (FWD_EN=1).
package pipe_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_LW  = 4'b1000,
        OP_SW  = 4'b1001,
        OP_LHB = 4'b1010,
        OP_LLB = 4'b1011,
        OP_B   = 4'b1100,
        OP_JAL = 4'b1101,
        OP_JR  = 4'b1110,
        OP_HLT = 4'b1111
    } op_t;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        FLUSH    = 3'd2,
        MEM_WAIT = 3'd3,
        HALT     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_t;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// hazard_cmp: register comparators for ID-stage hazards and EX-stage operand forwarding.
// Forwarding outputs are live only when PIPE_CTRL_FWD_EN is defined.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [15:0] id_instr,
    input  logic [15:0] ex_instr,
    input  logic [3:0]  ex_rd,
    input  logic [3:0]  mem_rd,
    input  logic [3:0]  wb_rd,
    input  logic        ex_wr,
    input  logic        mem_wr,
    input  logic        wb_wr,
    output logic        hazard,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    logic [3:0] rs, rt, rd;
    logic       hit_ex, hit_mem, load_use;

    // R0 is hard-wired, so it never selects a forwarded value
    function automatic logic [1:0] fwd_sel(input logic [3:0] r, input logic [3:0] m_rd, input logic m_wr,
                                           input logic [3:0] w_rd, input logic w_wr);
        return (r == 4'd0) ? FWD_RF : (m_wr && m_rd == r) ? FWD_MEM : (w_wr && w_rd == r) ? FWD_WB : FWD_RF;
    endfunction

    always_comb begin
        rs       = id_instr[7:4];
        rt       = id_instr[3:0];
        rd       = (id_instr[15:12] == OP_LHB || id_instr[15:12] == OP_SW) ? id_instr[11:8] : 4'd0;
        hit_ex   = ex_rd != 4'd0 && (ex_rd == rs || ex_rd == rt || ex_rd == rd);
        hit_mem  = mem_rd != 4'd0 && (mem_rd == rs || mem_rd == rt || mem_rd == rd);
        load_use = ex_instr[15:12] == OP_LW && hit_ex;
        hazard   = FWD_EN ? load_use : load_use || (ex_wr && hit_ex) || (mem_wr && hit_mem);
        fwd_a    = FWD_EN ? fwd_sel(ex_instr[7:4], mem_rd, mem_wr, wb_rd, wb_wr) : FWD_RF;
        fwd_b    = FWD_EN ? fwd_sel(ex_instr[3:0], mem_rd, mem_wr, wb_rd, wb_wr) : FWD_RF;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control FSM for load-use stalls, branch flushes, memory waits and halt.
// Define PIPE_CTRL_FWD_EN to forward operands instead of stalling on non-load RAW hazards.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] id_instr,
    input  logic [15:0] ex_instr,
    input  logic [3:0]  ex_rd,
    input  logic [3:0]  mem_rd,
    input  logic        ex_wr,
    input  logic        mem_wr,
    input  logic        ex_br_taken,
    input  logic        dmem_req,
    input  logic        dmem_rdy,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        exmem_hold,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        halted,
    output logic [2:0]  state
);

    state_t     state_q, state_d;
    logic       pend_q, pend_d, wb_wr_q, wb_wr_d;
    logic [3:0] wb_rd_q, wb_rd_d, wait_q, wait_d;
    logic       hazard, live, in_wait, mem_stall, redirect, do_flush, flush, stall, go_halt;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    hazard_cmp u_cmp (
        .id_instr (id_instr),
        .ex_instr (ex_instr),
        .ex_rd    (ex_rd),
        .mem_rd   (mem_rd),
        .wb_rd    (wb_rd_q),
        .ex_wr    (ex_wr),
        .mem_wr   (mem_wr),
        .wb_wr    (wb_wr_q),
        .hazard   (hazard),
        .fwd_a    (fwd_a_raw),
        .fwd_b    (fwd_b_raw)
    );

    always_comb begin
        live        = rst_n && state_q != HALT;
        in_wait     = state_q == MEM_WAIT;
        mem_stall   = live && dmem_req && !dmem_rdy;
        redirect    = ex_br_taken || ex_instr[15:12] == OP_JAL || ex_instr[15:12] == OP_JR || pend_q;
        // redirects seen while memory is busy are parked and replayed once RUN resumes
        do_flush    = live && redirect && !mem_stall && !in_wait;
        flush       = do_flush || (live && state_q == FLUSH);
        stall       = live && hazard && !mem_stall && !flush;
        go_halt     = live && ex_instr[15:12] == OP_HLT && !mem_stall && !in_wait;
        state_d     = (state_q == HALT) ? HALT : mem_stall ? MEM_WAIT : in_wait ? RUN :
                      go_halt ? HALT : do_flush ? FLUSH : stall ? LU_STALL : RUN;
        pend_d      = live && (mem_stall || in_wait) && redirect;
        wait_d      = (state_d == RUN) ? 4'd0 : (in_wait && wait_q != 4'hF) ? wait_q + 4'd1 : wait_q;
        wb_rd_d     = mem_rd;
        wb_wr_d     = mem_wr && !mem_stall;
        halted      = rst_n && state_q == HALT;
        pc_hold     = halted || mem_stall || stall;
        ifid_hold   = halted || mem_stall || stall;
        exmem_hold  = mem_stall;
        idex_bubble = do_flush || stall;
        ifid_flush  = flush;
        fwd_a       = rst_n ? fwd_a_raw : FWD_RF;
        fwd_b       = rst_n ? fwd_b_raw : FWD_RF;
        state       = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            wait_q  <= 4'd0;
            wb_rd_q <= 4'd0;
            wb_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
            wb_rd_q <= wb_rd_d;
            wb_wr_q <= wb_wr_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus with literal expectations plus a per-cycle reference model.
// Expectations adapt when PIPE_CTRL_FWD_EN is defined.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] id_instr = '0, ex_instr = '0;
    logic [3:0]  ex_rd = '0, mem_rd = '0;
    logic        ex_wr = 1'b0, mem_wr = 1'b0, ex_br_taken = 1'b0, dmem_req = 1'b0, dmem_rdy = 1'b0;
    logic        pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_hold, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [2:0]  state;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    pipe_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_instr    (id_instr),
        .ex_instr    (ex_instr),
        .ex_rd       (ex_rd),
        .mem_rd      (mem_rd),
        .ex_wr       (ex_wr),
        .mem_wr      (mem_wr),
        .ex_br_taken (ex_br_taken),
        .dmem_req    (dmem_req),
        .dmem_rdy    (dmem_rdy),
        .pc_hold     (pc_hold),
        .ifid_hold   (ifid_hold),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .exmem_hold  (exmem_hold),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .halted      (halted),
        .state       (state)
    );

    always #5 clk = ~clk;

    // observed vector: {pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_hold, halted, state, fwd_a, fwd_b}
    function automatic logic [12:0] xp(input logic [8:0] c, input logic [1:0] a, input logic [1:0] b);
        return {c, a, b};
    endfunction

    // does instruction ins read register r (R0 never counts)?
    function automatic bit reads(input logic [15:0] ins, input logic [3:0] r);
        if (r == 4'd0)
            return 1'b0;
        return ins[7:4] == r || ins[3:0] == r || ((ins[15:12] == 4'hA || ins[15:12] == 4'h9) && ins[11:8] == r);
    endfunction

    function automatic logic [1:0] src_of(input logic [3:0] r, input logic [3:0] mrd, input logic mwr,
                                          input logic [3:0] wrd, input logic wwr);
        if (r == 4'd0)
            return 2'b00;
        if (mwr && mrd == r)
            return 2'b01;
        if (wwr && wrd == r)
            return 2'b10;
        return 2'b00;
    endfunction

    // reference model: flags describing what the previous cycle left behind
    bit         m_halt, m_wait, m_fl2, m_stl, m_pend, m_wbw;
    bit         n_halt, n_wait, n_fl2, n_stl, n_pend, n_wbw;
    logic [3:0] m_wbr, n_wbr;
    logic [12:0] m_act, m_exp;
    logic [2:0]  m_dbg;
    logic [1:0]  m_fa, m_fb;
    bit          freeze, want, fl_now, lu, raw, stl;

    always @(negedge clk) begin
        cyc++;
        m_act = {pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_hold, halted, state, fwd_a, fwd_b};
        {n_halt, n_wait, n_fl2, n_stl, n_pend, n_wbw} = '0;
        n_wbr = mem_rd;
        if (!rst_n) begin
            m_exp = '0;
            n_wbr = '0;
        end else begin
            m_fa  = FWD ? src_of(ex_instr[7:4], mem_rd, mem_wr, m_wbr, m_wbw) : 2'b00;
            m_fb  = FWD ? src_of(ex_instr[3:0], mem_rd, mem_wr, m_wbr, m_wbw) : 2'b00;
            m_dbg = m_halt ? 3'd4 : m_wait ? 3'd3 : m_fl2 ? 3'd2 : m_stl ? 3'd1 : 3'd0;
            if (m_halt) begin
                m_exp  = {6'b110001, m_dbg, m_fa, m_fb};
                n_halt = 1'b1;
                n_wbw  = mem_wr;
            end else begin
                freeze = dmem_req && !dmem_rdy;
                want   = ex_br_taken || ex_instr[15:12] == 4'hD || ex_instr[15:12] == 4'hE || m_pend;
                fl_now = want && !freeze && !m_wait;
                lu     = ex_instr[15:12] == 4'h8 && reads(id_instr, ex_rd);
                raw    = (ex_wr && reads(id_instr, ex_rd)) || (mem_wr && reads(id_instr, mem_rd));
                stl    = (lu || (!FWD && raw)) && !freeze && !(fl_now || m_fl2);
                m_exp  = {freeze || stl, freeze || stl, fl_now || stl, fl_now || m_fl2, freeze, 1'b0, m_dbg, m_fa, m_fb};
                n_wait = freeze;
                n_halt = !freeze && !m_wait && ex_instr[15:12] == 4'hF;
                n_fl2  = !freeze && !m_wait && !n_halt && fl_now;
                n_stl  = !freeze && !m_wait && !n_halt && !fl_now && stl;
                n_pend = (freeze || m_wait) && want;
                n_wbw  = mem_wr && !freeze;
            end
        end
        n_total++;
        if (m_act === m_exp)
            n_pass++;
        else
            $display("FAIL model cycle %0d: got %b, expected %b", cyc, m_act, m_exp);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {m_halt, m_wait, m_fl2, m_stl, m_pend, m_wbw} <= '0;
            m_wbr <= '0;
        end else begin
            {m_halt, m_wait, m_fl2, m_stl, m_pend, m_wbw} <= {n_halt, n_wait, n_fl2, n_stl, n_pend, n_wbw};
            m_wbr <= n_wbr;
        end
    end

    task automatic s(input logic rn, input logic [15:0] id, input logic [15:0] ex, input logic [3:0] erd,
                     input logic [3:0] mrd, input logic ew, input logic mw, input logic br, input logic dq,
                     input logic dr, input logic [12:0] exp, input string nm);
        logic [12:0] act;
        @(posedge clk);
        #1;
        rst_n = rn;
        id_instr = id;
        ex_instr = ex;
        ex_rd = erd;
        mem_rd = mrd;
        ex_wr = ew;
        mem_wr = mw;
        ex_br_taken = br;
        dmem_req = dq;
        dmem_rdy = dr;
        @(negedge clk);
        act = {pc_hold, ifid_hold, idex_bubble, ifid_flush, exmem_hold, halted, state, fwd_a, fwd_b};
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    task automatic idle(input logic [12:0] exp, input string nm);
        s(1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, exp, nm);
    endtask

    initial begin
        s(0, 16'h0531, 16'h8300, 3, 0, 1, 0, 0, 0, 0, xp(9'b000000_000, 0, 0), "reset_a");
        s(0, 16'h0531, 16'h8300, 3, 0, 1, 0, 1, 1, 0, xp(9'b000000_000, 0, 0), "reset_b");
        idle(xp(9'b000000_000, 0, 0), "idle");
        s(1, 16'h0531, 16'h8300, 3, 0, 1, 0, 0, 0, 0, xp(9'b111000_000, 0, 0), "lu_stall");
        s(1, 16'h0531, 16'h0000, 0, 3, 0, 1, 0, 0, 0, xp(FWD ? 9'b000000_001 : 9'b111000_001, 0, 0), "lu_after");
        s(1, 16'h0000, 16'h0531, 5, 0, 1, 0, 0, 0, 0,
          xp(FWD ? 9'b000000_000 : 9'b000000_001, FWD ? 2'b10 : 2'b00, 0), "lu_release");
        idle(xp(9'b000000_000, 0, 0), "lu_run");
        s(1, 16'h0, 16'hC000, 0, 0, 0, 0, 1, 0, 0, xp(9'b001100_000, 0, 0), "br_c1");
        idle(xp(9'b000100_010, 0, 0), "br_c2");
        idle(xp(9'b000000_000, 0, 0), "br_run");
        s(1, 16'h0, 16'hD000, 0, 0, 0, 0, 0, 0, 0, xp(9'b001100_000, 0, 0), "jal_c1");
        idle(xp(9'b000100_010, 0, 0), "jal_c2");
        idle(xp(9'b000000_000, 0, 0), "jal_run");
        s(1, 16'h0531, 16'h8300, 3, 0, 1, 0, 1, 0, 0, xp(9'b001100_000, 0, 0), "lu_with_br");
        s(1, 16'h0531, 16'h8300, 3, 0, 1, 0, 0, 0, 0, xp(9'b000100_010, 0, 0), "lu_in_flush");
        idle(xp(9'b000000_000, 0, 0), "flush_run");
        s(1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1, 0, xp(9'b110010_000, 0, 0), "mw_c1");
        s(1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1, 0, xp(9'b110010_011, 0, 0), "mw_c2");
        s(1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1, 0, xp(9'b110010_011, 0, 0), "mw_c3");
        s(1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1, 1, xp(9'b000000_011, 0, 0), "mw_rdy");
        idle(xp(9'b000000_000, 0, 0), "mw_run");
        s(1, 16'h0, 16'hE000, 0, 0, 0, 0, 0, 1, 0, xp(9'b110010_000, 0, 0), "jr_wait1");
        s(1, 16'h0, 16'hE000, 0, 0, 0, 0, 0, 1, 0, xp(9'b110010_011, 0, 0), "jr_wait2");
        s(1, 16'h0, 16'hE000, 0, 0, 0, 0, 0, 1, 1, xp(9'b000000_011, 0, 0), "jr_rdy");
        idle(xp(9'b001100_000, 0, 0), "jr_flush1");
        idle(xp(9'b000100_010, 0, 0), "jr_flush2");
        idle(xp(9'b000000_000, 0, 0), "jr_run");
        s(1, 16'h0, 16'hE000, 0, 0, 0, 0, 0, 1, 0, xp(9'b110010_000, 0, 0), "rw_enter");
        s(0, 16'h0, 16'hE000, 0, 0, 0, 0, 0, 1, 0, xp(9'b000000_000, 0, 0), "rw_reset");
        idle(xp(9'b000000_000, 0, 0), "rw_no_pend");
        idle(xp(9'b000000_000, 0, 0), "rw_idle");
        s(1, 16'h0, 16'hF000, 0, 0, 0, 0, 0, 0, 0, xp(9'b000000_000, 0, 0), "hlt_ex");
        idle(xp(9'b110001_100, 0, 0), "hlt_1");
        s(1, 16'h0, 16'h0, 0, 0, 0, 0, 1, 1, 0, xp(9'b110001_100, 0, 0), "hlt_hold");
        s(0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, xp(9'b000000_000, 0, 0), "hlt_reset");
        idle(xp(9'b000000_000, 0, 0), "hlt_run");
        s(1, 16'h0123, 16'h0200, 2, 0, 1, 0, 0, 0, 0, xp(FWD ? 9'b000000_000 : 9'b111000_000, 0, 0), "raw_ex");
        s(1, 16'h0123, 16'h0000, 0, 2, 0, 1, 0, 0, 0, xp(FWD ? 9'b000000_000 : 9'b111000_001, 0, 0), "raw_mem");
        s(1, 16'h0123, 16'h0000, 0, 0, 0, 0, 0, 0, 0, xp(FWD ? 9'b000000_000 : 9'b000000_001, 0, 0), "raw_done");
        idle(xp(9'b000000_000, 0, 0), "raw_run");
        s(1, 16'h0500, 16'h8000, 0, 0, 1, 0, 0, 0, 0, xp(9'b000000_000, 0, 0), "r0_no_hazard");
        s(1, 16'hA400, 16'h8400, 4, 0, 1, 0, 0, 0, 0, xp(9'b111000_000, 0, 0), "lhb_rd_src");
        idle(xp(9'b000000_001, 0, 0), "lhb_state");
        idle(xp(9'b000000_000, 0, 0), "lhb_run");
        s(1, 16'h0, 16'h1024, 0, 2, 0, 1, 0, 0, 0, xp(9'b000000_000, FWD ? 2'b01 : 2'b00, 0), "fwd_mem");
        s(1, 16'h0, 16'h1024, 0, 4, 0, 1, 0, 0, 0,
          xp(9'b000000_000, FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00), "fwd_wb");
        s(1, 16'h0, 16'h1004, 0, 4, 0, 1, 0, 0, 0, xp(9'b000000_000, 0, FWD ? 2'b01 : 2'b00), "fwd_r0");
        s(1, 16'h0, 16'h1000, 0, 0, 0, 1, 0, 0, 0, xp(9'b000000_000, 0, 0), "fwd_none");
        for (int i = 0; i < 18; i++)
            s(1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1, 0, xp(i == 0 ? 9'b110010_000 : 9'b110010_011, 0, 0), "long_wait");
        s(1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1, 1, xp(9'b000000_011, 0, 0), "long_rdy");
        idle(xp(9'b000000_000, 0, 0), "long_run");
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have id_instr  input  16  instruction currently in ID.
REQ-004 SHALL have ex_instr  input  16  instruction currently in EX; opcode is bits 15:12.
REQ-005 SHALL have ex_rd, mem_rd  input  4 each  destination registers in EX and MEM.
REQ-006 SHALL have ex_wr, mem_wr  input  1 each  register-file write pending in EX and MEM.
REQ-007 SHALL have ex_br_taken  input  1  EX resolved a taken branch (B) this cycle.
REQ-008 SHALL have dmem_req  input  1  MEM-stage LW/SW issued to data memory.
REQ-009 SHALL have dmem_rdy  input  1  data memory completed the access.
REQ-010 SHALL have pc_hold, ifid_hold  output  1 each  freeze PC and the IF/ID register.
REQ-011 SHALL have idex_bubble, ifid_flush  output  1 each  insert NOP into ID/EX; clear IF/ID.
REQ-012 SHALL have exmem_hold  output  1  freeze EX/MEM and all earlier stages.
REQ-013 SHALL have fwd_a, fwd_b  output  2 each  EX operand source: 00 regfile, 01 from MEM, 10 from WB.
REQ-014 SHALL have halted  output  1  HLT retired.
REQ-015 SHALL have state  output  3  current FSM state for debug.

Function
REQ-016 SHALL implement states RUN, LU_STALL, FLUSH, MEM_WAIT, HALT.
REQ-017 Priority per cycle SHALL be: MEM_WAIT > FLUSH > LU_STALL > RUN.
REQ-018 Load-use hazard: ex_instr opcode 1000 (LW), and ex_rd equal to a nonzero source register of id_instr (rs=7:4, rt=3:0; for LHB and SW, rd=11:8 also counts as a source). The FSM SHALL enter LU_STALL for exactly 1 cycle, asserting pc_hold, ifid_hold and idex_bubble.
REQ-019 Register 0 SHALL never cause a hazard or a forward.
REQ-020 On ex_br_taken, or an ex_instr opcode of 1101 (JAL) or 1110 (JR), the FSM SHALL assert ifid_flush and idex_bubble in that cycle, and enter FLUSH for 1 further cycle with ifid_flush high; the total penalty is 2 cycles.
REQ-021 With dmem_req high and dmem_rdy low, the FSM SHALL enter MEM_WAIT and hold exmem_hold, pc_hold and ifid_hold high until the cycle in which dmem_rdy is high. It SHALL return to RUN on the next edge.
REQ-022 A 4-bit wait counter SHALL count MEM_WAIT cycles and saturate at 15. It is visible only through state, and clears on entering RUN.
REQ-023 A flush requested during MEM_WAIT SHALL be held pending and applied on the first cycle after MEM_WAIT; it SHALL not be lost.
REQ-024 A load-use hazard coinciding with a flush SHALL be discarded, because the flush removes the dependent instruction.
REQ-025 When ex_instr opcode 1111 (HLT) reaches EX, the FSM SHALL enter HALT on the next edge. In HALT, pc_hold, ifid_hold and halted are high, and only rst_n exits the state.
REQ-026 Outputs SHALL be combinational from state and current inputs, with no extra latency beyond that stated.

Reset
REQ-027 While rst_n is low, the FSM SHALL be in state=RUN, all hold, flush and bubble outputs 0, fwd_a=fwd_b=00, halted=0, wait counter 0.
REQ-028 Reset asserted mid-stall or mid-MEM_WAIT SHALL abort the stall immediately, with no pending flush retained.

Configuration
REQ-029 Macro PIPE_CTRL_FWD_EN defined: the block SHALL generate fwd_a and fwd_b, with MEM winning over WB on a match. Non-load RAW hazards then cause no stall.
REQ-030 Macro undefined: fwd_a=fwd_b=00 constantly, and any RAW match against EX or MEM with a pending write SHALL stall through LU_STALL until the writer leaves MEM.

Structure
REQ-031 A shared package SHALL hold the opcode constants (LW, SW, LHB, LLB, B, JAL, JR, HLT), the state encoding, and the fwd select encoding.
REQ-032 Hazard and forward comparison SHALL reside in sub-module hazard_cmp. The FSM and counter SHALL reside in pipe_ctrl.

Verification
REQ-033 LW R3 in EX, ADD R5,R3,R1 in ID -> one cycle with pc_hold=ifid_hold=idex_bubble=1, then RUN.
REQ-034 B taken (ex_br_taken=1) -> ifid_flush=1 for 2 consecutive cycles, idex_bubble=1 in cycle 1.
REQ-035 dmem_req=1, dmem_rdy low 3 cycles -> exmem_hold high exactly 3 cycles, RUN on the next edge.
REQ-036 JR in EX while MEM_WAIT active -> flush occurs on the first cycle after dmem_rdy.
REQ-037 With PIPE_CTRL_FWD_EN: ADD R2 in MEM, SUB reads R2 as rs in EX -> fwd_a=01, no stall. Same source register R0 -> fwd_a=00.
REQ-038 HLT in EX -> halted=1 next cycle and persists; rst_n pulse low -> state=RUN, halted=0.
